// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit. It uses a shift-add multiplier and a restoring
// divider, holds architectural HI/LO, supports MTHI/MTLO writes, and stalls on busy hazards.
module mips_muldiv_unit #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [width-1:0] rs_data,
  input  logic [width-1:0] rt_data,
  input  logic             hilo_rd,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int W2 = 2 * width;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [width-1:0] hi_q, hi_d;
  logic [width-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             neg_pq_q, neg_pq_d;
  logic             neg_r_q, neg_r_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [width-1:0] opnd_q, opnd_d;

  function automatic logic [width-1:0] neg_w(input logic [width-1:0] v);
    return ~v + width'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  function automatic logic [width-1:0] mag_w(input logic signed [width-1:0] v,
                                             input logic is_signed);
    return (is_signed && (v < 0)) ? neg_w(v) : v;
  endfunction

  logic             start_sgn, start_dz;
  logic [width-1:0] a_mag, b_mag;

  // A zero divisor keeps the raw dividend so that it rotates intact into HI.
  assign start_sgn = ~op[0];
  assign start_dz  = op[1] & (rt_data == '0);
  assign a_mag     = mag_w(rs_data, start_sgn & ~start_dz);
  assign b_mag     = mag_w(rt_data, start_sgn);

  logic [width:0]  mul_sum, div_trial;
  logic            div_borrow;
  logic [W2-1:0]   mul_step, div_step;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide: acc = {remainder, dividend shifting into quotient}.
  always_comb begin
    mul_sum    = {1'b0, acc_q[W2-1:width]} + {1'b0, opnd_q};
    mul_step   = acc_q[0] ? {mul_sum, acc_q[width-1:1]} : {1'b0, acc_q[W2-1:1]};
    div_trial  = acc_q[W2-1:width-1] - {1'b0, opnd_q};
    div_borrow = div_trial[width] & ~dz_q;
    div_step   = div_borrow ? {acc_q[W2-2:0], 1'b0}
                            : {div_trial[width-1:0], acc_q[width-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_pq_d = neg_pq_q;
    neg_r_d  = neg_r_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!flush) begin
            state_d  = RUN;
            cnt_d    = 5'd31;
            is_div_d = op[1];
            dz_d     = start_dz;
            neg_pq_d = start_sgn & ~start_dz & (rs_data[width-1] ^ rt_data[width-1]);
            neg_r_d  = start_sgn & ~start_dz & op[1] & rs_data[width-1];
            opnd_d   = op[1] ? b_mag : a_mag;
            acc_d    = {{width{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          if (cnt_q == 5'd0) state_d = FIX;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = neg_pq_q ? neg_w(acc_q[width-1:0]) : acc_q[width-1:0];
            hi_d = neg_r_q  ? neg_w(acc_q[W2-1:width]) : acc_q[W2-1:width];
          end else begin
            {hi_d, lo_d} = neg_pq_q ? neg_2w(acc_q) : acc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_pq_q <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_pq_q <= neg_pq_d;
      neg_r_q  <= neg_r_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
  end

  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | hilo_rd | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit. It checks results, latency, stall, flush and reset
// against hand-computed values.
module tb_mips_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_b, start, hilo_rd, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;
  logic        busy, done, stall;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.width(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .hilo_rd(hilo_rd), .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat;
    issue(o, a, b);
    check_eq({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(33));
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    rst_b = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hilo_rd = 1'b1; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    repeat (2) tick();
    check_eq("rst_hi", 64'(hi), 64'(0));
    check_eq("rst_lo", 64'(lo), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_stall", 64'(stall), 64'(0));
    hilo_rd = 1'b0;
    #2 rst_b = 1'b1;
    tick();

    rs_data = 32'hA5A5_0001; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check_eq("mt_both_hi", 64'(hi), 64'(32'hA5A5_0001));
    check_eq("mt_both_lo", 64'(lo), 64'(32'hA5A5_0001));
    rs_data = 32'h12; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'(32'h12));
    check_eq("mtlo_hi", 64'(hi), 64'(32'hA5A5_0001));

    start = 1'b1; op = MULT; rs_data = 32'hFFFF_FFFE; rt_data = 32'd3; mthi = 1'b1;
    #1 check_eq("idle_start_stall", 64'(stall), 64'(0));
    tick();
    start = 1'b0; mthi = 1'b0;
    check_eq("start_drops_mthi", 64'(hi), 64'(32'hA5A5_0001));
    check_eq("mult_busy", 64'(busy), 64'(1));
    wait_done(lat);
    check_eq("mult_lat", 64'(lat), 64'(33));
    check_eq("mult_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check_eq("mult_lo", 64'(lo), 64'(32'hFFFF_FFFA));
    tick();

    run_op("multu",   MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_n7_2", DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_n2", DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7", DIVU, 32'd100,     32'd7,         32'h0000_0002, 32'h0000_000E);
    run_op("divu_by0", DIVU, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_by0_neg", DIV, 32'hFFFF_FF00, 32'd0,       32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    issue(MULT, 32'd7, 32'hFFFF_FFFD);
    repeat (9) tick();
    hilo_rd = 1'b1;
    #1 check_eq("stall_hilo_rd", 64'(stall), 64'(1));
    tick();
    hilo_rd = 1'b0; mthi = 1'b1; rs_data = 32'hDEAD_BEEF;
    #1 check_eq("stall_mthi", 64'(stall), 64'(1));
    tick();
    mthi = 1'b0; start = 1'b1; op = MULTU; rs_data = 32'd2; rt_data = 32'd2;
    #1 check_eq("stall_start", 64'(stall), 64'(1));
    tick();
    start = 1'b0;
    #1 check_eq("stall_quiet", 64'(stall), 64'(0));
    check_eq("stall_hi_hold", 64'(hi), 64'(32'h4000_0000));
    check_eq("stall_lo_hold", 64'(lo), 64'(32'h0000_0000));
    wait_done(lat);
    check_eq("stall_lat", 64'(lat), 64'(21));
    check_eq("stall_res_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check_eq("stall_res_lo", 64'(lo), 64'(32'hFFFF_FFEB));
    tick();
    check_eq("stalled_start_dropped", 64'(busy), 64'(0));

    mtlo = 1'b1; rs_data = 32'h55;
    tick();
    mtlo = 1'b0;
    check_eq("flush_pre_lo", 64'(lo), 64'(32'h55));
    issue(MULT, 32'd3, 32'd3);
    repeat (19) tick();
    check_eq("flush_pre_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'(0));
    check_eq("flush_lo", 64'(lo), 64'(32'h55));
    check_eq("flush_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    check_eq("flush_no_done", 64'(ndone), 64'(0));
    check_eq("flush_lo_after", 64'(lo), 64'(32'h55));

    issue(DIVU, 32'd100, 32'd7);
    wait_done(lat);
    check_eq("b2b_first_lat", 64'(lat), 64'(33));
    check_eq("b2b_first_hi", 64'(hi), 64'(32'h2));
    check_eq("b2b_first_lo", 64'(lo), 64'(32'hE));
    issue(MULTU, 32'd5, 32'd6);
    check_eq("b2b_accept", 64'(busy), 64'(1));
    wait_done(lat);
    check_eq("b2b_spacing", 64'(lat + 1), 64'(34));
    check_eq("b2b_second_hi", 64'(hi), 64'(32'h0));
    check_eq("b2b_second_lo", 64'(lo), 64'(32'h1E));
    tick();

    mthi = 1'b1; rs_data = 32'h77;
    tick();
    mthi = 1'b0;
    check_eq("pre_rst_hi", 64'(hi), 64'(32'h77));
    issue(DIV, 32'd100, 32'd7);
    repeat (10) tick();
    #2 rst_b = 1'b0;
    #1;
    check_eq("midrst_hi", 64'(hi), 64'(0));
    check_eq("midrst_lo", 64'(lo), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_done", 64'(done), 64'(0));
    tick();
    #2 rst_b = 1'b1;
    repeat (3) tick();
    check_eq("postrst_busy", 64'(busy), 64'(0));
    check_eq("postrst_lo", 64'(lo), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
